// File: rtl/dot_product_chunk_streamer.sv
// rtl/dot_product_chunk_streamer.sv - streams padded matrix-row/vector chunks to the dot-product controller
module dot_product_chunk_streamer #(
    parameter int NOE           = 16,
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic [addr_width-1:0]                mat_addr,
    input  logic [element_width*no_of_units-1:0] mat_rdata,
    output logic [addr_width-1:0]                vec_addr,
    input  logic [element_width*no_of_units-1:0] vec_rdata,
    output logic [element_width*no_of_units-1:0] first_row_plus_additional,
    output logic [element_width*no_of_units-1:0] vector2,
    output logic                                 outsider_read_now,
    input  logic                                 chunk_ack,
    output logic                                 row_done,
    output logic [31:0]                          row_count,
    output logic                                 busy,
    output logic                                 done
);

    localparam int additional     = no_of_units - (NOE % no_of_units);
    localparam int total          = NOE + additional;
    localparam int chunks_per_row = total / no_of_units;
    localparam int BUS_W          = element_width * no_of_units;

    localparam logic [31:0]           LAST_CHUNK = 32'(chunks_per_row - 1);
    localparam logic [31:0]           LAST_ROW   = 32'(NOE - 1);
    localparam logic [31:0]           UNITS      = 32'(no_of_units);
    localparam logic [31:0]           NOE_W      = 32'(NOE);
    localparam logic [addr_width-1:0] ADDR_ONE   = addr_width'(1);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, ADVANCE} state_t;

    state_t                state_q, state_d;
    logic [31:0]           row_q, row_d;
    logic [31:0]           chunk_q, chunk_d;
    logic [31:0]           row_count_q, row_count_d;
    logic [addr_width-1:0] mat_addr_q, mat_addr_d;
    logic [addr_width-1:0] vec_addr_q, vec_addr_d;
    logic [BUS_W-1:0]      mat_data_q, mat_data_d;
    logic [BUS_W-1:0]      vec_data_q, vec_data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  row_done_q, row_done_d;
    logic                  done_q, done_d;
    logic [BUS_W-1:0]      mat_pad, vec_pad;

    // Lane k sits in the MSB-first slot; lanes past the last real element read as zero.
    always_comb begin
        mat_pad = '0;
        vec_pad = '0;
        for (int k = 0; k < no_of_units; k++) begin
            if (chunk_q * UNITS + 32'(k) < NOE_W) begin
                mat_pad[element_width*(no_of_units-k)-1 -: element_width] =
                    mat_rdata[element_width*(no_of_units-k)-1 -: element_width];
                vec_pad[element_width*(no_of_units-k)-1 -: element_width] =
                    vec_rdata[element_width*(no_of_units-k)-1 -: element_width];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        chunk_d     = chunk_q;
        row_count_d = row_count_q;
        mat_addr_d  = mat_addr_q;
        vec_addr_d  = vec_addr_q;
        mat_data_d  = mat_data_q;
        vec_data_d  = vec_data_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        row_done_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    row_d       = '0;
                    chunk_d     = '0;
                    row_count_d = '0;
                    mat_addr_d  = '0;
                    vec_addr_d  = '0;
                    busy_d      = 1'b1;
                end
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                mat_data_d = mat_pad;
                vec_data_d = vec_pad;
                valid_d    = 1'b1;
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (chunk_ack) begin
                    valid_d = 1'b0;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                // Matrix address is row*chunks_per_row+chunk, which is just a running count.
                mat_addr_d = mat_addr_q + ADDR_ONE;
                state_d    = FETCH;
                if (chunk_q == LAST_CHUNK) begin
                    chunk_d     = '0;
                    vec_addr_d  = '0;
                    row_d       = row_q + 32'd1;
                    row_count_d = row_count_q + 32'd1;
                    row_done_d  = 1'b1;
                    if (row_q == LAST_ROW) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    chunk_d    = chunk_q + 32'd1;
                    vec_addr_d = vec_addr_q + ADDR_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            chunk_q     <= '0;
            row_count_q <= '0;
            mat_addr_q  <= '0;
            vec_addr_q  <= '0;
            mat_data_q  <= '0;
            vec_data_q  <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            row_done_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            chunk_q     <= chunk_d;
            row_count_q <= row_count_d;
            mat_addr_q  <= mat_addr_d;
            vec_addr_q  <= vec_addr_d;
            mat_data_q  <= mat_data_d;
            vec_data_q  <= vec_data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            row_done_q  <= row_done_d;
            done_q      <= done_d;
        end
    end

    assign mat_addr                  = mat_addr_q;
    assign vec_addr                  = vec_addr_q;
    assign first_row_plus_additional = mat_data_q;
    assign vector2                   = vec_data_q;
    assign outsider_read_now         = valid_q;
    assign row_done                  = row_done_q;
    assign row_count                 = row_count_q;
    assign busy                      = busy_q;
    assign done                      = done_q;

endmodule

// File: tb/tb_dot_product_chunk_streamer.sv
// tb/tb_dot_product_chunk_streamer.sv - scoreboard bench for dot_product_chunk_streamer
module tb_dot_product_chunk_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start16, ack16, start12, ack12;
    logic [15:0]  mat_addr16, vec_addr16, mat_addr12, vec_addr12;
    logic [255:0] mat_rdata16, vec_rdata16, mat_rdata12, vec_rdata12;
    logic [255:0] bus_m16, bus_v16, bus_m12, bus_v12;
    logic         valid16, valid12, row_done16, row_done12;
    logic         busy16, busy12, done16, done12;
    logic [31:0]  row_count16, row_count12;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0]  maddr;
        logic [15:0]  vaddr;
        logic [255:0] mbus;
        logic [255:0] vbus;
    } exp_t;

    exp_t q16[$];
    exp_t q12[$];
    exp_t cur16, cur12;
    int   popped16 = 0, rd16 = 0, dn16 = 0, dn12 = 0;
    logic pv16 = 1'b0, pv12 = 1'b0;

    always #5 clk = ~clk;

    dot_product_chunk_streamer u_dut16 (
        .clk(clk), .reset(reset), .start(start16),
        .mat_addr(mat_addr16), .mat_rdata(mat_rdata16),
        .vec_addr(vec_addr16), .vec_rdata(vec_rdata16),
        .first_row_plus_additional(bus_m16), .vector2(bus_v16),
        .outsider_read_now(valid16), .chunk_ack(ack16),
        .row_done(row_done16), .row_count(row_count16),
        .busy(busy16), .done(done16)
    );

    dot_product_chunk_streamer #(.NOE(12)) u_dut12 (
        .clk(clk), .reset(reset), .start(start12),
        .mat_addr(mat_addr12), .mat_rdata(mat_rdata12),
        .vec_addr(vec_addr12), .vec_rdata(vec_rdata12),
        .first_row_plus_additional(bus_m12), .vector2(bus_v12),
        .outsider_read_now(valid12), .chunk_ack(ack12),
        .row_done(row_done12), .row_count(row_count12),
        .busy(busy12), .done(done12)
    );

    // Memories with one-cycle read latency; every lane of a word holds the same value.
    always @(posedge clk) begin
        mat_rdata16 <= {8{32'h100 + {16'd0, mat_addr16}}};
        vec_rdata16 <= {8{32'h200 + {16'd0, vec_addr16}}};
        mat_rdata12 <= {8{32'h100 + {16'd0, mat_addr12}}};
        vec_rdata12 <= {8{32'h200 + {16'd0, vec_addr12}}};
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_bus(input int noe, input int c, input logic [31:0] val);
        logic [255:0] b;
        b = '0;
        for (int k = 0; k < 8; k++)
            if (c * 8 + k < noe) b[32*(8-k)-1 -: 32] = val;
        return b;
    endfunction

    task automatic push_run(input int which);
        exp_t e;
        int   noe, cpr;
        noe = (which != 0) ? 12 : 16;
        cpr = (which != 0) ? 2 : 3;
        for (int r = 0; r < noe; r++) begin
            for (int c = 0; c < cpr; c++) begin
                e.maddr = 16'(r * cpr + c);
                e.vaddr = 16'(c);
                e.mbus  = exp_bus(noe, c, 32'h100 + 32'(r * cpr + c));
                e.vbus  = exp_bus(noe, c, 32'h200 + 32'(c));
                if (which != 0) q12.push_back(e);
                else q16.push_back(e);
            end
        end
    endtask

    // Scoreboard: each new chunk-valid pops the next expected chunk.
    always @(negedge clk) begin
        if (!reset) begin
            pv16 = 1'b0;
            pv12 = 1'b0;
        end else begin
            if (valid16 && !pv16) begin
                check("q16_nonempty", 256'(q16.size() != 0), 256'd1);
                if (q16.size() != 0) begin
                    cur16 = q16.pop_front();
                    check("mat_addr16", 256'(mat_addr16), 256'(cur16.maddr));
                    check("vec_addr16", 256'(vec_addr16), 256'(cur16.vaddr));
                    check("mat_bus16", bus_m16, cur16.mbus);
                    check("vec_bus16", bus_v16, cur16.vbus);
                    popped16++;
                end
            end
            if (valid12 && !pv12) begin
                check("q12_nonempty", 256'(q12.size() != 0), 256'd1);
                if (q12.size() != 0) begin
                    cur12 = q12.pop_front();
                    check("mat_addr12", 256'(mat_addr12), 256'(cur12.maddr));
                    check("vec_addr12", 256'(vec_addr12), 256'(cur12.vaddr));
                    check("mat_bus12", bus_m12, cur12.mbus);
                    check("vec_bus12", bus_v12, cur12.vbus);
                end
            end
            if (row_done16) begin
                check("row_done_spacing", 256'(popped16 % 3), 256'd0);
                rd16++;
            end
            if (done16) dn16++;
            if (done12) dn12++;
            pv16 = valid16;
            pv12 = valid12;
        end
    end

    task automatic serve(input int which, input int hold);
        int   n;
        logic v;
        n = 0;
        v = (which != 0) ? valid12 : valid16;
        while (!v && n < 50) begin
            @(negedge clk);
            n++;
            v = (which != 0) ? valid12 : valid16;
        end
        check("valid_wait", 256'(v), 256'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 256'(valid16), 256'd1);
            check("hold_mat", bus_m16, cur16.mbus);
            check("hold_vec", bus_v16, cur16.vbus);
        end
        if (which != 0) ack12 = 1'b1;
        else ack16 = 1'b1;
        @(negedge clk);
        ack12 = 1'b0;
        ack16 = 1'b0;
        v = (which != 0) ? valid12 : valid16;
        check("valid_drop_after_ack", 256'(v), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; start16 = 1'b0; ack16 = 1'b0; start12 = 1'b0; ack12 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 256'(valid16), 256'd0);
        check("rst_busy", 256'(busy16), 256'd0);
        check("rst_row_count", 256'(row_count16), 256'd0);
        check("rst_mat_addr", 256'(mat_addr16), 256'd0);
        check("rst_mat_bus", bus_m16, 256'd0);
        reset = 1'b1;
        @(negedge clk);

        // Default geometry with back-pressure on chunk 0 and a stray start at row 7.
        push_run(0);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("lat_e0", 256'(valid16), 256'd0);
        check("busy_after_start", 256'(busy16), 256'd1);
        @(negedge clk);
        check("lat_e1", 256'(valid16), 256'd0);
        @(negedge clk);
        check("lat_e2", 256'(valid16), 256'd1);
        serve(0, 10);
        @(negedge clk); check("ack_lat_1", 256'(valid16), 256'd0);
        @(negedge clk); check("ack_lat_2", 256'(valid16), 256'd0);
        @(negedge clk); check("ack_lat_3", 256'(valid16), 256'd1);
        for (int i = 1; i < 48; i++) begin
            if (i == 21) begin
                start16 = 1'b1;
                @(negedge clk);
                start16 = 1'b0;
            end
            serve(0, 0);
        end
        repeat (3) @(negedge clk);
        check("run1_done_count", 256'(dn16), 256'd1);
        check("run1_row_done_count", 256'(rd16), 256'd16);
        check("run1_row_count", 256'(row_count16), 256'd16);
        check("run1_busy", 256'(busy16), 256'd0);
        check("run1_queue_empty", 256'(q16.size()), 256'd0);

        // NOE=12: second chunk of each row has lanes 4..7 padded.
        push_run(1);
        start12 = 1'b1;
        @(negedge clk);
        start12 = 1'b0;
        for (int i = 0; i < 24; i++) serve(1, 0);
        repeat (3) @(negedge clk);
        check("run12_done_count", 256'(dn12), 256'd1);
        check("run12_row_count", 256'(row_count12), 256'd12);
        check("run12_queue_empty", 256'(q12.size()), 256'd0);

        // Asynchronous reset while row 3 chunk 1 is presented.
        push_run(0);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 10; i++) serve(0, 0);
        n = 0;
        while (!valid16 && n < 50) begin @(negedge clk); n++; end
        check("row3_chunk1_valid", 256'(valid16), 256'd1);
        check("row3_chunk1_addr", 256'(mat_addr16), 256'd10);
        #2 reset = 1'b0;
        #1;
        check("async_valid", 256'(valid16), 256'd0);
        check("async_busy", 256'(busy16), 256'd0);
        check("async_mat_addr", 256'(mat_addr16), 256'd0);
        check("async_vec_addr", 256'(vec_addr16), 256'd0);
        check("async_mat_bus", bus_m16, 256'd0);
        check("async_vec_bus", bus_v16, 256'd0);
        check("async_row_count", 256'(row_count16), 256'd0);
        q16.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle_busy", 256'(busy16), 256'd0);
        check("post_rst_no_done", 256'(dn16), 256'd1);

        // Restart with ack held high throughout, including alongside start.
        push_run(0);
        popped16 = 0;
        rd16 = 0;
        ack16 = 1'b1;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("restart_busy", 256'(busy16), 256'd1);
        n = 0;
        while (dn16 < 2 && n < 2000) begin @(negedge clk); n++; end
        ack16 = 1'b0;
        check("run3_done_count", 256'(dn16), 256'd2);
        check("run3_chunks", 256'(popped16), 256'd48);
        check("run3_row_done_count", 256'(rd16), 256'd16);
        check("run3_row_count", 256'(row_count16), 256'd16);
        check("run3_queue_empty", 256'(q16.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
